// File: rtl/nibble_op_sequencer.sv
// nibble_op_sequencer: control block for the nibble-serial datapath.
// Walks one operand nibble per clock, forward (LSB-first) for ADD/SUB/XFER
// and reverse (MSB-first) for CMP. It drives the operand-store address and
// write strobe, performs the per-nibble add/sub/compare/transfer step with
// carry, and reports done plus condition flags.
// Optional build macro NIBBLE_SEQ_CMP_EARLY_EXIT_EN: CMP finishes on the
// first differing nibble instead of always walking the full operand.
module nibble_op_sequencer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] arg2_width,
  input  logic             abort,
  output logic [WIDTH-1:0] nib_idx,
  input  logic [3:0]       a_nib,
  input  logic [3:0]       b_nib,
  output logic             wr_en,
  output logic [3:0]       wr_nib,
  output logic             done,
  output logic             busy,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_lt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_CMP, OP_XFER} op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] nib_idx_q, nib_idx_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             lt_q, lt_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_lt_q, flag_lt_d;

  logic [4:0]       sum;
  logic [3:0]       res_nib;
  logic             first_diff;
  logic             finish;

  // Per-nibble datapath: add / subtract (A + ~B + c) / transfer / compare.
  always_comb begin
    sum     = {1'b0, a_nib}
            + {1'b0, (op_q == OP_SUB) ? ~b_nib : b_nib}
            + {4'b0000, carry_q};
    res_nib = 4'h0;
    case (op_q)
      OP_ADD, OP_SUB: res_nib = sum[3:0];
      OP_XFER:        res_nib = a_nib;
      default:        res_nib = 4'h0;
    endcase
    // zero_q doubles as "no difference seen yet" while comparing MSB-first.
    first_diff = (op_q == OP_CMP) && zero_q && (a_nib != b_nib);
`ifdef NIBBLE_SEQ_CMP_EARLY_EXIT_EN
    finish = (nib_idx_q == last_q) || first_diff;
`else
    finish = (nib_idx_q == last_q);
`endif
  end

  // Next-state, accumulator and flag update logic.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    last_d    = last_q;
    nib_idx_d = nib_idx_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    lt_d      = lt_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    flag_lt_d = flag_lt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = op_t'(req_op);
          carry_d = (op_t'(req_op) == OP_SUB);
          zero_d  = 1'b1;
          lt_d    = 1'b0;
          state_d = S_RUN;
          if (op_t'(req_op) == OP_CMP) begin
            nib_idx_d = arg2_width;
            last_d    = '0;
          end else begin
            nib_idx_d = '0;
            last_d    = arg2_width;
          end
        end
      end
      S_RUN: begin
        if (op_q == OP_ADD || op_q == OP_SUB) carry_d = sum[4];
        if (op_q == OP_CMP) begin
          zero_d = zero_q & (a_nib == b_nib);
          if (first_diff) lt_d = (a_nib < b_nib);
        end else begin
          zero_d = zero_q & (res_nib == 4'h0);
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (finish) begin
          state_d   = S_DONE;
          flag_c_d  = carry_d;
          flag_z_d  = zero_d;
          flag_lt_d = lt_d;
        end else if (op_q == OP_CMP) begin
          nib_idx_d = nib_idx_q - WIDTH'(1);
        end else begin
          nib_idx_d = nib_idx_q + WIDTH'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, accumulator and flag registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      last_q    <= '0;
      nib_idx_q <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_lt_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q   <= state_d;
      op_q      <= op_d;
      last_q    <= last_d;
      nib_idx_q <= nib_idx_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      lt_q      <= lt_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
      flag_lt_q <= flag_lt_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign wr_en     = (state_q == S_RUN) && (op_q != OP_CMP);
  assign wr_nib    = (state_q == S_RUN) ? res_nib : 4'h0;
  assign nib_idx   = nib_idx_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign flag_lt   = flag_lt_q;

endmodule

// File: tb/tb_nibble_op_sequencer.sv
// Directed testbench for nibble_op_sequencer. The operand store is modelled
// as two 32-bit vectors read combinationally at nib_idx; all expected values
// are hand-computed constants.
module tb_nibble_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'd0;
  logic [2:0] arg2_width = 3'd0;
  logic       abort = 1'b0;
  logic [2:0] nib_idx;
  logic [3:0] a_nib, b_nib;
  logic       wr_en;
  logic [3:0] wr_nib;
  logic       done, busy, flag_c, flag_z, flag_lt;

  logic [31:0] a_vec = '0;
  logic [31:0] b_vec = '0;

  int total = 0;
  int bad   = 0;

  // Record of the RUN cycles of the last operation.
  logic [2:0] rec_idx [0:15];
  logic       rec_we  [0:15];
  logic [3:0] rec_wr  [0:15];
  int         nrec;
  int         done_cyc;
  logic       any_we;

  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, CMP = 2'd2, XFER = 2'd3;

  assign a_nib = a_vec[{nib_idx, 2'b00} +: 4];
  assign b_nib = b_vec[{nib_idx, 2'b00} +: 4];

  nibble_op_sequencer #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .arg2_width(arg2_width), .abort(abort),
    .nib_idx(nib_idx), .a_nib(a_nib), .b_nib(b_nib),
    .wr_en(wr_en), .wr_nib(wr_nib), .done(done), .busy(busy),
    .flag_c(flag_c), .flag_z(flag_z), .flag_lt(flag_lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request, record every RUN cycle, locate the done pulse and
  // confirm req_ready comes back the cycle after it.
  task automatic do_op(input logic [1:0] op, input logic [2:0] w,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    a_vec = a; b_vec = b; req_op = op; arg2_width = w; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    nrec = 0; done_cyc = -1; any_we = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy && nrec < 16) begin
        rec_idx[nrec] = nib_idx;
        rec_we[nrec]  = wr_en;
        rec_wr[nrec]  = wr_nib;
        any_we        = any_we | wr_en;
        nrec++;
      end
    end
    check("done_seen", (done_cyc != -1), 1);
    check("ready_in_done", req_ready, 0);
    @(negedge clk);
    check("ready_after_done", req_ready, 1);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_idx", nib_idx, 0);
    check("rst_flags", {flag_c, flag_z, flag_lt}, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // ADD 0x0FF + 0x001: writes 0,0,1; carry ripples out of nibbles 0 and 1.
    do_op(ADD, 3'd2, 32'h0FF, 32'h001);
    check("add_runlen", nrec, 3);
    check("add_done_cyc", done_cyc, 4);
    check("add_idx", {rec_idx[0], rec_idx[1], rec_idx[2]}, {3'd0, 3'd1, 3'd2});
    check("add_wr", {rec_wr[0], rec_wr[1], rec_wr[2]}, 12'h001);
    check("add_we", {rec_we[0], rec_we[1], rec_we[2]}, 3'b111);
    check("add_flags", {flag_c, flag_z, flag_lt}, 3'b000);

    // SUB 0x100 - 0x001 = 0x0FF: writes F,F,0, no final borrow.
    do_op(SUB, 3'd2, 32'h100, 32'h001);
    check("sub_wr", {rec_wr[0], rec_wr[1], rec_wr[2]}, 12'hFF0);
    check("sub_flags", {flag_c, flag_z, flag_lt}, 3'b100);

    // SUB 0x000 - 0x001: borrow out -> flag_c = 0.
    do_op(SUB, 3'd2, 32'h000, 32'h001);
    check("subb_wr", {rec_wr[0], rec_wr[1], rec_wr[2]}, 12'hFFF);
    check("subb_flags", {flag_c, flag_z, flag_lt}, 3'b000);

    // XFER of a zero operand.
    do_op(XFER, 3'd2, 32'h000, 32'h7A5);
    check("xfer_we", {rec_we[0], rec_we[1], rec_we[2]}, 3'b111);
    check("xfer_wr", {rec_wr[0], rec_wr[1], rec_wr[2]}, 12'h000);
    check("xfer_flags", {flag_c, flag_z, flag_lt}, 3'b010);

    // CMP 0x123 vs 0x124: MSB-first walk, difference only at nibble 0.
    do_op(CMP, 3'd2, 32'h123, 32'h124);
    check("cmp_runlen", nrec, 3);
    check("cmp_done_cyc", done_cyc, 4);
    check("cmp_idx", {rec_idx[0], rec_idx[1], rec_idx[2]}, {3'd2, 3'd1, 3'd0});
    check("cmp_no_we", any_we, 0);
    check("cmp_flags", {flag_c, flag_z, flag_lt}, 3'b001);

    // CMP 0x223 vs 0x124: differs at the top nibble, A > B.
    do_op(CMP, 3'd2, 32'h223, 32'h124);
    check("cmp2_flags", {flag_c, flag_z, flag_lt}, 3'b000);
`ifdef NIBBLE_SEQ_CMP_EARLY_EXIT_EN
    check("cmp2_done_cyc", done_cyc, 2);
    check("cmp2_runlen", nrec, 1);
`else
    check("cmp2_done_cyc", done_cyc, 4);
    check("cmp2_runlen", nrec, 3);
`endif

    // CMP 0x19 vs 0x21: top nibble decides A < B; lower nibble (9 > 1) ignored.
    do_op(CMP, 3'd1, 32'h19, 32'h21);
    check("cmp3_flags", {flag_c, flag_z, flag_lt}, 3'b001);
`ifdef NIBBLE_SEQ_CMP_EARLY_EXIT_EN
    check("cmp3_done_cyc", done_cyc, 2);
`else
    check("cmp3_done_cyc", done_cyc, 3);
`endif

    // CMP equal operands: always full length.
    do_op(CMP, 3'd2, 32'h5A3, 32'h5A3);
    check("cmpeq_done_cyc", done_cyc, 4);
    check("cmpeq_flags", {flag_c, flag_z, flag_lt}, 3'b010);

    // Single-nibble ADD F + 1.
    do_op(ADD, 3'd0, 32'hF, 32'h1);
    check("add0_runlen", nrec, 1);
    check("add0_idx", rec_idx[0], 0);
    check("add0_we_wr", {rec_we[0], rec_wr[0]}, 5'h10);
    check("add0_done_cyc", done_cyc, 2);
    check("add0_flags", {flag_c, flag_z, flag_lt}, 3'b110);

    // Abort an 8-nibble ADD at nib_idx 3; flags must keep c=1 z=1 lt=0.
    @(negedge clk);
    a_vec = 32'h11111111; b_vec = 32'h11111111;
    req_op = ADD; arg2_width = 3'd7; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (nib_idx == 3'd3) break;
    end
    check("abort_reach_idx", nib_idx, 3);
    abort = 1'b1;
    check("abort_wr_en", wr_en, 1);
    check("abort_wr_nib", wr_nib, 4'h2);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_ready", req_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_flags", {flag_c, flag_z, flag_lt}, 3'b110);
    begin
      logic saw_done;
      saw_done = done;
      for (int cyc = 0; cyc < 3; cyc++) begin
        @(negedge clk);
        saw_done = saw_done | done;
      end
      check("abort_no_done", saw_done, 0);
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a_vec = 32'h11111111; b_vec = 32'h22222222;
    req_op = ADD; arg2_width = 3'd7; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_idx", nib_idx, 0);
    check("arst_ready_busy", {req_ready, busy, done, wr_en}, 4'b1000);
    check("arst_flags", {flag_c, flag_z, flag_lt}, 3'b000);
    #1 rst = 1'b0;

    // A fresh ADD after reset works normally.
    do_op(ADD, 3'd2, 32'h0FF, 32'h001);
    check("post_rst_wr", {rec_wr[0], rec_wr[1], rec_wr[2]}, 12'h001);
    check("post_rst_done_cyc", done_cyc, 4);
    check("post_rst_flags", {flag_c, flag_z, flag_lt}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
